// File: rtl/pulse_sweep_scheduler.sv
// Frequency-sweep sequencer for the pulse-mask generator: steps divider/duty from start to stop.
// Optional SWEEP_REPEAT_EN: on final dwell completion reload start_div and keep sweeping.
module pulse_sweep_scheduler #(
  parameter int W      = 32,
  parameter int FRAC_W = 8,
  parameter int IDX_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_i,
  input  logic [W-1:0]      start_div_i,
  input  logic [W-1:0]      stop_div_i,
  input  logic [W-1:0]      step_div_i,
  input  logic [IDX_W-1:0]  dwell_i,
  input  logic [FRAC_W-1:0] duty_frac_i,
  input  logic              period_end_i,
  output logic [W-1:0]      divider_o,
  output logic [W-1:0]      duty_o,
  output logic              sweep_active_o,
  output logic              sweep_done_o,
  output logic              cfg_err_o,
  output logic [IDX_W-1:0]  step_idx_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_SWEEP = 2'b10,
    S_HOLD  = 2'b11
  } state_e;

  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  state_e           state_q, state_d;
  logic [W-1:0]     div_q, div_d, duty_q, duty_d;
  logic [W-1:0]     stop_q, stop_d, step_q, step_d;
  logic [IDX_W-1:0] idx_q, idx_d, dcnt_q, dcnt_d, dlast_q, dlast_d;
  logic             up_q, up_d, done_q, done_d, err_q, err_d;
`ifdef SWEEP_REPEAT_EN
  logic [W-1:0]     start_q, start_d;
`endif

  // Full-width product so large dividers never lose high bits; a nonzero
  // request never collapses to a zero-length pulse.
  function automatic logic [W-1:0] calc(input logic [W-1:0] d, input logic [FRAC_W-1:0] f);
    logic [W+FRAC_W-1:0] p;
    logic [W-1:0]        r;
    p = {{FRAC_W{1'b0}}, d} * {{W{1'b0}}, f};
    r = p[W+FRAC_W-1:FRAC_W];
    if (r == '0 && d != '0 && f != '0) r = {{(W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Next divider, clamped to stop on overshoot; the extra bit catches wrap.
  logic [W:0]   sum, dif;
  logic [W-1:0] nxt;
  always_comb begin
    sum = {1'b0, div_q} + {1'b0, step_q};
    dif = {1'b0, div_q} - {1'b0, step_q};
    if (up_q) nxt = (sum > {1'b0, stop_q}) ? stop_q : sum[W-1:0];
    else      nxt = (dif[W] || dif[W-1:0] < stop_q) ? stop_q : dif[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    duty_d  = duty_q;
    stop_d  = stop_q;
    step_d  = step_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    dlast_d = dlast_q;
    up_d    = up_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef SWEEP_REPEAT_EN
    start_d = start_q;
`endif
    case (state_q)
      S_IDLE: if (!abort_i && arm_i) state_d = S_ARMED;
      S_ARMED: begin
        if (abort_i || !arm_i) begin
          state_d = S_IDLE;
          div_d   = '0;
          duty_d  = '0;
        end else if (trig_i) begin
          if (start_div_i == '0 || stop_div_i == '0) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            stop_d  = stop_div_i;
            step_d  = step_div_i;
            up_d    = (stop_div_i >= start_div_i);
            dlast_d = (dwell_i == '0) ? '0 : dwell_i - IDX_ONE;
            div_d   = start_div_i;
            duty_d  = calc(start_div_i, duty_frac_i);
            idx_d   = '0;
            dcnt_d  = '0;
`ifdef SWEEP_REPEAT_EN
            start_d = start_div_i;
`endif
            state_d = S_SWEEP;
          end
        end
      end
      S_SWEEP: begin
        if (abort_i || !arm_i) begin
          state_d = S_IDLE;
          div_d   = '0;
          duty_d  = '0;
        end else if (period_end_i) begin
          if (dcnt_q == dlast_q) begin
            dcnt_d = '0;
            if (div_q == stop_q) begin
              done_d = 1'b1;
`ifdef SWEEP_REPEAT_EN
              div_d  = start_q;
              duty_d = calc(start_q, duty_frac_i);
              idx_d  = '0;
`else
              state_d = S_HOLD;
`endif
            end else begin
              div_d  = nxt;
              duty_d = calc(nxt, duty_frac_i);
              if (idx_q != '1) idx_d = idx_q + IDX_ONE;
            end
          end else begin
            dcnt_d = dcnt_q + IDX_ONE;
          end
        end
      end
      S_HOLD: begin
        if (abort_i || !arm_i) begin
          state_d = S_IDLE;
          div_d   = '0;
          duty_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      duty_q  <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      dlast_q <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SWEEP_REPEAT_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      dlast_q <= dlast_d;
      up_q    <= up_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SWEEP_REPEAT_EN
      start_q <= start_d;
`endif
    end
  end

  assign divider_o      = div_q;
  assign duty_o         = duty_q;
  assign sweep_active_o = (state_q == S_SWEEP);
  assign sweep_done_o   = done_q;
  assign cfg_err_o      = err_q;
  assign step_idx_o     = idx_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pulse_sweep_scheduler.sv
// Bench for pulse_sweep_scheduler: directed sweep cases then random traffic against a
// model that precomputes each sweep's divider list at trigger time.
module tb_pulse_sweep_scheduler;
  localparam int W = 32, FRAC_W = 8, IDX_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1, arm = 1'b0, abort = 1'b0, trig = 1'b0, pe = 1'b0;
  logic [W-1:0]      start_div = '0, stop_div = '0, step_div = '0;
  logic [IDX_W-1:0]  dwell = '0;
  logic [FRAC_W-1:0] frac = '0;
  logic [W-1:0]      divider_o, duty_o;
  logic              sweep_active_o, sweep_done_o, cfg_err_o;
  logic [IDX_W-1:0]  step_idx_o;
  logic [1:0]        state_o;

  pulse_sweep_scheduler #(.W(W), .FRAC_W(FRAC_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .reset_i(reset), .arm_i(arm), .abort_i(abort), .trig_i(trig),
    .start_div_i(start_div), .stop_div_i(stop_div), .step_div_i(step_div),
    .dwell_i(dwell), .duty_frac_i(frac), .period_end_i(pe),
    .divider_o(divider_o), .duty_o(duty_o), .sweep_active_o(sweep_active_o),
    .sweep_done_o(sweep_done_o), .cfg_err_o(cfg_err_o), .step_idx_o(step_idx_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the whole divider sequence is listed at trigger time.
  int     m_st, m_pos, m_per, m_dw;
  longint m_div, m_duty, m_idx, m_stop;
  bit     m_done, m_err;
  longint m_list[$];

  function automatic longint calc(longint d, longint f);
    longint r;
    r = (d * f) >> FRAC_W;
    if (r == 0 && d != 0 && f != 0) r = 1;
    return r;
  endfunction

  task automatic m_build(longint s, longint e, longint st);
    longint cur;
    m_list.delete();
    cur = s;
    m_list.push_back(cur);
    if (st != 0)
      while (cur != e) begin
        if (e >= s) cur = (cur + st > e) ? e : cur + st;
        else        cur = (cur - st < e) ? e : cur - st;
        m_list.push_back(cur);
      end
  endtask

  task automatic m_step();
    m_done = 0;
    if (reset) begin
      m_st = 0; m_div = 0; m_duty = 0; m_idx = 0; m_err = 0; m_per = 0;
      return;
    end
    case (m_st)
      0: if (!abort && arm) m_st = 1;
      1: if (abort || !arm) m_st = 0;
         else if (trig) begin
           if (start_div == 0 || stop_div == 0) m_err = 1;
           else begin
             m_err = 0;
             m_build(longint'(start_div), longint'(stop_div), longint'(step_div));
             m_pos = 0; m_per = 0;
             m_stop = stop_div;
             m_dw = (dwell == 0) ? 1 : int'(dwell);
             m_div = start_div; m_duty = calc(m_div, frac); m_idx = 0;
             m_st = 2;
           end
         end
      2: if (abort || !arm) begin m_st = 0; m_div = 0; m_duty = 0; end
         else if (pe) begin
           m_per++;
           if (m_per == m_dw) begin
             m_per = 0;
             if (m_div == m_stop) begin
               m_done = 1;
`ifdef SWEEP_REPEAT_EN
               m_pos = 0; m_div = m_list[0]; m_duty = calc(m_div, frac); m_idx = 0;
`else
               m_st = 3;
`endif
             end else begin
               if (m_pos < m_list.size() - 1) m_pos++;
               m_div = m_list[m_pos]; m_duty = calc(m_div, frac);
               if (m_idx < 65535) m_idx++;
             end
           end
         end
      3: if (abort || !arm) begin m_st = 0; m_div = 0; m_duty = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_step();
    chk("state", state_o, m_st);
    chk("divider", divider_o, m_div);
    chk("duty", duty_o, m_duty);
    chk("active", sweep_active_o, m_st == 2);
    chk("done", sweep_done_o, m_done);
    chk("cfg_err", cfg_err_o, m_err);
    chk("step_idx", step_idx_o, m_idx);
  endtask

  task automatic fire(input longint s, input longint e, input longint st, input int dw, input int fr);
    start_div = W'(s); stop_div = W'(e); step_div = W'(st);
    dwell = IDX_W'(dw); frac = FRAC_W'(fr);
    trig = 1; tick(); trig = 0;
  endtask

  task automatic run_pe(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      pe = 1; tick(); if (sweep_done_o) nd++;
      pe = 0; tick(); if (sweep_done_o) nd++;
    end
  endtask

  int nd;

  initial begin
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_div", divider_o, 0);
    chk("rst_idx", step_idx_o, 0);
    reset = 0; arm = 1; tick();

    // up sweep 100..130 step 10, two periods per step, half duty
    fire(100, 130, 10, 2, 128);
    chk("up_first_div", divider_o, 100);
    chk("up_first_duty", duty_o, 50);
    run_pe(7, nd);
    chk("up_no_early_done", nd, 0);
    chk("up_last_div", divider_o, 130);
    run_pe(1, nd);
    chk("up_done", nd, 1);
`ifndef SWEEP_REPEAT_EN
    chk("up_hold", state_o, 3);
    chk("up_hold_div", divider_o, 130);
    chk("up_hold_duty", duty_o, 65);
    chk("up_hold_idx", step_idx_o, 3);
`endif
    arm = 0; tick(); arm = 1; tick();

    // down sweep with clamp 100,90,80,75
    fire(100, 75, 10, 1, 128);
    run_pe(3, nd);
    chk("dn_clamp_div", divider_o, 75);
    chk("dn_clamp_duty", duty_o, 37);
    chk("dn_idx", step_idx_o, 3);
    run_pe(1, nd);
    chk("dn_done", nd, 1);
    arm = 0; tick(); arm = 1; tick();

    // bad config then good config
    fire(100, 0, 10, 1, 128);
    chk("err_set", cfg_err_o, 1);
    chk("err_armed", state_o, 1);
    fire(100, 130, 10, 1, 128);
    chk("err_clr", cfg_err_o, 0);
    chk("err_sweep", state_o, 2);

    // abort coincident with period_end
    run_pe(1, nd);
    abort = 1; pe = 1; tick();
    chk("abort_state", state_o, 0);
    chk("abort_div", divider_o, 0);
    chk("abort_nodone", sweep_done_o, 0);
    abort = 0; pe = 0; tick();

    // duty floor
    fire(3, 3, 1, 1, 1);
    chk("duty_floor", duty_o, 1);
    arm = 0; tick(); arm = 1; tick();
    fire(3, 3, 1, 1, 0);
    chk("duty_zero", duty_o, 0);
    arm = 0; tick();

`ifdef SWEEP_REPEAT_EN
    arm = 1; tick();
    fire(10, 20, 10, 1, 128);
    run_pe(6, nd);
    chk("rep_done_cnt", nd, 3);
    chk("rep_div", divider_o, 10);
    chk("rep_idx", step_idx_o, 0);
    arm = 0; tick();
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      arm   = ($urandom_range(0, 149) != 0);
      abort = ($urandom_range(0, 199) == 0);
      trig  = ($urandom_range(0, 7) == 0);
      pe    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) frac = FRAC_W'($urandom);
      if (trig) begin
        case ($urandom_range(0, 9))
          0: begin start_div = 32'hFFFF_FF00; stop_div = 32'hFFFF_FFF0; step_div = 32'h8000_0000; end
          1: begin start_div = 50; stop_div = 10; step_div = 32'hFFFF_FFF0; end
          default: begin
            start_div = ($urandom_range(0, 9) == 0) ? 0 : W'($urandom_range(1, 60));
            stop_div  = ($urandom_range(0, 9) == 0) ? 0 : W'($urandom_range(1, 60));
            step_div  = ($urandom_range(0, 9) == 0) ? 0 : W'($urandom_range(1, 20));
          end
        endcase
        dwell = IDX_W'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
